// File: rtl/rx_gearbox_32_66_if.sv
// Bus bundle for the 32-to-66 RX gearbox: raw 32-bit SerDes words in, 66-bit
// blocks (64-bit payload + 2-bit sync header) plus bitslip bookkeeping out.
interface rx_gearbox_32_66_if;
  // serdes_in_valid qualifies serdes_in_data on the edge it is sampled high; there
  // is no backpressure. serdes_rx_valid is a one-cycle strobe per assembled block,
  // and serdes_rx_data/serdes_rx_hdr hold their value between strobes.
  logic [31:0] serdes_in_data;
  logic        serdes_in_valid;
  logic        serdes_rx_bitslip;
  logic [63:0] serdes_rx_data;
  logic [1:0]  serdes_rx_hdr;
  logic        serdes_rx_valid;
  logic [6:0]  slip_count;

  modport master (
    output serdes_in_data, serdes_in_valid, serdes_rx_bitslip,
    input  serdes_rx_data, serdes_rx_hdr, serdes_rx_valid, slip_count
  );

  modport slave (
    input  serdes_in_data, serdes_in_valid, serdes_rx_bitslip,
    output serdes_rx_data, serdes_rx_hdr, serdes_rx_valid, slip_count
  );
endinterface

// File: rtl/rx_gearbox_32_66.sv
// 32-bit to 66-bit RX gearbox: appends words into a 98-bit bit buffer, applies
// edge-triggered bitslips, and emits one 66-bit block whenever 66 bits are held.
module rx_gearbox_32_66 #(
  parameter int BIT_REVERSE    = 0,
  parameter int OUT_DATA_WIDTH = 64,
  parameter int OUT_HDR_WIDTH  = 2
) (
  input  logic               rx_clk,
  input  logic               rx_rst_n,
  rx_gearbox_32_66_if.slave  gb
);

  localparam int BLK = OUT_DATA_WIDTH + OUT_HDR_WIDTH;
  localparam int BW  = 98;

  logic [BW-1:0] shreg_q;
  logic [6:0]    cnt_q;
  logic          slip_q;

  logic [31:0]   word_rev;
  logic [31:0]   word;
  logic [BW-1:0] b_app, b_slp, b_nxt;
  logic [6:0]    c_app, c_slp, c_nxt;
  logic          slip;
  logic          emit;

  always_comb begin
    for (int i = 0; i < 32; i++) word_rev[i] = gb.serdes_in_data[31-i];
    word = (BIT_REVERSE != 0) ? word_rev : gb.serdes_in_data;

    // Bits above the fill count are always zero, so the append is a plain OR.
    b_app = shreg_q;
    c_app = cnt_q;
    if (gb.serdes_in_valid) begin
      b_app = shreg_q | ({66'b0, word} << cnt_q);
      c_app = cnt_q + 7'd32;
    end

    // A slip on an empty buffer has nothing to discard and is lost.
    slip  = gb.serdes_rx_bitslip & ~slip_q & (c_app != 7'd0);
    b_slp = slip ? (b_app >> 1) : b_app;
    c_slp = c_app - {6'b0, slip};

    emit  = (c_slp >= 7'(BLK));
    b_nxt = emit ? (b_slp >> BLK) : b_slp;
    c_nxt = emit ? (c_slp - 7'(BLK)) : c_slp;
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      shreg_q            <= '0;
      cnt_q              <= '0;
      slip_q             <= 1'b0;
      gb.serdes_rx_data  <= '0;
      gb.serdes_rx_hdr   <= '0;
      gb.serdes_rx_valid <= 1'b0;
      gb.slip_count      <= '0;
    end else begin
      shreg_q            <= b_nxt;
      cnt_q              <= c_nxt;
      slip_q             <= gb.serdes_rx_bitslip;
      gb.serdes_rx_valid <= emit;
      if (emit) begin
        gb.serdes_rx_data <= b_slp[BLK-1:OUT_HDR_WIDTH];
        gb.serdes_rx_hdr  <= b_slp[OUT_HDR_WIDTH-1:0];
      end
      if (slip) gb.slip_count <= gb.slip_count + 7'd1;
    end
  end

endmodule

// File: tb/tb_rx_gearbox_32_66.sv
// Bench for rx_gearbox_32_66: block streams built from known 66-bit blocks,
// a valid-pattern vector table, slip/reset corner sequences and a bit-reversed instance.
module tb_rx_gearbox_32_66;

  logic rx_clk;
  logic rx_rst_n;

  rx_gearbox_32_66_if gb ();
  rx_gearbox_32_66_if gb2 ();

  rx_gearbox_32_66 #(.BIT_REVERSE(0)) dut (
    .rx_clk   (rx_clk),
    .rx_rst_n (rx_rst_n),
    .gb       (gb)
  );

  rx_gearbox_32_66 #(.BIT_REVERSE(1)) dut_rev (
    .rx_clk   (rx_clk),
    .rx_rst_n (rx_rst_n),
    .gb       (gb2)
  );

  // clock / reset
  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        in_valid;
    logic [31:0] data;
    logic        exp_valid;
  } vec_t;

  vec_t        vec[66];
  logic [65:0] exp_q[$];
  bit          stream_q[$];
  logic [65:0] last_blk;
  logic        check_en;
  int          n_tests;
  int          n_fail;
  int          pulses;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_stream(input int filler, input int nblk, input int base);
    logic [65:0] blk;
    stream_q.delete();
    for (int f = 0; f < filler; f++) stream_q.push_back(1'b0);
    for (int b = 0; b < nblk; b++) begin
      blk = {64'(base + b), 2'b01};
      for (int j = 0; j < 66; j++) stream_q.push_back(blk[j]);
    end
  endtask

  function automatic logic [31:0] next_word();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = (stream_q.size() > 0) ? stream_q.pop_front() : 1'b0;
    return w;
  endfunction

  // driver: apply inputs, clock once, sample 1 ns after the edge
  task automatic step(input logic v, input logic [31:0] d, input logic s);
    gb.serdes_in_valid   = v;
    gb.serdes_in_data    = d;
    gb.serdes_rx_bitslip = s;
    @(posedge rx_clk);
    #1;
    if (gb.serdes_rx_valid) begin
      pulses++;
      last_blk = {gb.serdes_rx_data, gb.serdes_rx_hdr};
      if (check_en) begin
        if (exp_q.size() == 0) check("sb_unexpected_block", last_blk, 66'h0 - 66'h1);
        else check("sb_block", last_blk, exp_q.pop_front());
      end
    end
  endtask

  task automatic step2(input logic [31:0] d);
    gb2.serdes_in_valid = 1'b1;
    gb2.serdes_in_data  = d;
    @(posedge rx_clk);
    #1;
    gb2.serdes_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_rst_n = 1'b0;
    #2;
    @(posedge rx_clk);
    #1;
    rx_rst_n = 1'b1;
    last_blk = '0;
    exp_q.delete();
    pulses = 0;
  endtask

  task automatic run_table(input int n, input int base);
    int nb;
    nb = 0;
    for (int i = 0; i < n; i++) begin
      if (vec[i].exp_valid) begin
        exp_q.push_back({64'(base + nb), 2'b01});
        nb++;
      end
      step(vec[i].in_valid, vec[i].data, 1'b0);
      check($sformatf("valid_v%0d", i), 66'(gb.serdes_rx_valid), 66'(vec[i].exp_valid));
      if (!vec[i].exp_valid)
        check($sformatf("hold_v%0d", i), {gb.serdes_rx_data, gb.serdes_rx_hdr}, last_blk);
    end
  endtask

  task automatic fill_continuous(input int base);
    build_stream(0, 16, base);
    for (int k = 1; k <= 33; k++)
      vec[k-1] = '{1'b1, next_word(), ((32 * k) / 66) != ((32 * (k - 1)) / 66)};
  endtask

  initial begin
    logic [63:0] prev;
    logic        have_prev;
    int          n_aligned;

    n_tests  = 0;
    n_fail   = 0;
    pulses   = 0;
    check_en = 1'b1;
    last_blk = '0;
    rx_rst_n = 1'b0;
    gb.serdes_in_valid    = 1'b0;
    gb.serdes_in_data     = '0;
    gb.serdes_rx_bitslip  = 1'b0;
    gb2.serdes_in_valid   = 1'b0;
    gb2.serdes_in_data    = '0;
    gb2.serdes_rx_bitslip = 1'b0;

    // reset state
    #12;
    check("rst_valid", 66'(gb.serdes_rx_valid), 66'd0);
    check("rst_data", 66'(gb.serdes_rx_data), 66'd0);
    check("rst_hdr", 66'(gb.serdes_rx_hdr), 66'd0);
    check("rst_slip", 66'(gb.slip_count), 66'd0);
    do_reset();

    // continuous stream: 33 words -> 16 blocks, data 0..15
    fill_continuous(0);
    run_table(33, 0);
    check("cont_pulses", 66'(pulses), 66'd16);
    check("cont_last_data", 66'(last_blk[65:2]), 66'd15);
    check("cont_sb_drained", 66'(exp_q.size()), 66'd0);

    // valid toggling 1,0,1,0 with junk on idle cycles
    do_reset();
    build_stream(0, 16, 100);
    for (int k = 1; k <= 33; k++) begin
      vec[2*k-2] = '{1'b1, next_word(), ((32 * k) / 66) != ((32 * (k - 1)) / 66)};
      vec[2*k-1] = '{1'b0, $urandom, 1'b0};
    end
    run_table(66, 100);
    check("tog_pulses", 66'(pulses), 66'd16);
    check("tog_sb_drained", 66'(exp_q.size()), 66'd0);

    // partial data then asynchronous reset: outputs clear, junk discarded
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    check("pre_rst_valid0", 66'(gb.serdes_rx_valid), 66'd0);
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    check("pre_rst_valid1", 66'(gb.serdes_rx_valid), 66'd0);
    gb.serdes_in_valid = 1'b0;
    rx_rst_n = 1'b0;
    #2;
    check("mid_rst_data", 66'(gb.serdes_rx_data), 66'd0);
    check("mid_rst_hdr", 66'(gb.serdes_rx_hdr), 66'd0);
    check("mid_rst_valid", 66'(gb.serdes_rx_valid), 66'd0);
    @(posedge rx_clk);
    #1;
    rx_rst_n = 1'b1;
    last_blk = '0;
    pulses   = 0;
    exp_q.delete();
    fill_continuous(200);
    run_table(33, 200);
    check("post_rst_pulses", 66'(pulses), 66'd16);

    // slip on empty buffer is dropped; held bitslip slips once; count wraps
    do_reset();
    check_en = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    check("slip_empty_dropped", 66'(gb.slip_count), 66'd0);
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b1);
    check("slip_held_once", 66'(gb.slip_count), 66'd1);
    step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 126; i++) begin
      step(1'b1, $urandom, 1'b1);
      step(1'b1, $urandom, 1'b0);
    end
    check("slip_count_127", 66'(gb.slip_count), 66'd127);
    step(1'b1, $urandom, 1'b1);
    step(1'b1, $urandom, 1'b0);
    check("slip_count_wrap", 66'(gb.slip_count), 66'd0);

    // 5-bit offset stream realigned by 5 bitslip pulses
    do_reset();
    build_stream(5, 30, 0);
    have_prev = 1'b0;
    n_aligned = 0;
    prev      = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      step(1'b1, next_word(), (cyc % 10 == 3) && (cyc <= 43));
      if (cyc >= 43 && gb.serdes_rx_valid) begin
        check("align_hdr", 66'(gb.serdes_rx_hdr), 66'd1);
        if (have_prev) check("align_order", 66'(gb.serdes_rx_data), 66'(prev + 64'd1));
        prev      = gb.serdes_rx_data;
        have_prev = 1'b1;
        n_aligned++;
      end
    end
    check("align_slip_count", 66'(gb.slip_count), 66'd5);
    check("align_enough_blocks", 66'(n_aligned >= 6), 66'd1);
    check_en = 1'b1;

    // bit-reversed instance: word bit 0 lands at B[31] (payload bit 29)
    do_reset();
    step2(32'h0000_0001);
    step2(32'h0);
    check("rev_no_early_valid", 66'(gb2.serdes_rx_valid), 66'd0);
    step2(32'h0);
    check("rev_a_valid", 66'(gb2.serdes_rx_valid), 66'd1);
    check("rev_a_block", {gb2.serdes_rx_data, gb2.serdes_rx_hdr}, {64'h0000_0000_2000_0000, 2'b00});
    do_reset();
    step2(32'h8000_0000);
    step2(32'h0);
    step2(32'h0);
    check("rev_b_valid", 66'(gb2.serdes_rx_valid), 66'd1);
    check("rev_b_block", {gb2.serdes_rx_data, gb2.serdes_rx_hdr}, {64'h0, 2'b01});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_gearbox_32_66.md
RX_GEARBOX_32_66 -- requirements
Module: rx_gearbox_32_66

Interface
REQ-001 Parameter BIT_REVERSE, default 0: when 1, each input word is bit-reversed before it enters the buffer.
REQ-002 Parameter OUT_DATA_WIDTH, default 64; parameter OUT_HDR_WIDTH, default 2; only 64/2 is supported.
REQ-003 rx_clk  input  1  single clock for all logic.
REQ-004 rx_rst_n  input  1  asynchronous, active-low reset.
REQ-005 serdes_in_data  input  32  raw received bits; bit 0 is received first.
REQ-006 serdes_in_valid  input  1  serdes_in_data is accepted on this rising edge.
REQ-007 serdes_rx_bitslip  input  1  bitslip request from the downstream 10G PHY RX stage; level signal.
REQ-008 serdes_rx_data  output  64  assembled block payload, feeding the PHY RX serdes_rx_data.
REQ-009 serdes_rx_hdr  output  2  assembled sync header, feeding the PHY RX serdes_rx_hdr.
REQ-010 serdes_rx_valid  output  1  single-cycle qualifier for serdes_rx_data/serdes_rx_hdr.
REQ-011 slip_count  output  7  wrapping count of bitslips applied.

Function
REQ-012 Buffer B SHALL be at least 98 bits wide.
- Fill count C SHALL range 0..97.
- B[0] is the oldest bit.
REQ-013 On each edge with serdes_in_valid=1, the input word (bit-reversed if BIT_REVERSE=1) SHALL be appended at position C, and C SHALL become C+32.
REQ-014 Slip event:
- A rising edge of serdes_rx_bitslip (registered-previous 0, current 1) SHALL discard B[0], shift B down by 1, and decrement C.
- This applies after the append of REQ-013 on the same edge.
REQ-015 A slip event with post-append C=0 SHALL be dropped silently.
- slip_count SHALL NOT increment for a dropped slip.
- Slip events are not queued.
REQ-016 Block emission:
- After append and slip, if C>=66, the next registered outputs SHALL be serdes_rx_hdr=B[1:0], serdes_rx_data=B[65:2] and serdes_rx_valid=1.
- B SHALL then shift down by 66 and C SHALL decrease by 66, all on the same edge.
REQ-017 At most one block SHALL be emitted per cycle. Because C<=65 at the start of every cycle, C never exceeds 97.
REQ-018 serdes_rx_valid SHALL be 1 for exactly one cycle per emitted block. serdes_rx_data and serdes_rx_hdr SHALL hold their last values while serdes_rx_valid=0.
REQ-019 Latency: a block whose last bit arrives on edge N SHALL be presented on the outputs immediately after edge N.
REQ-020 Continuous input without slips SHALL yield exactly 16 blocks per 33 accepted words.
- Emission pattern: emit on cycle k when floor(32k/66) increments.
- The first block appears after the 3rd accepted word.
REQ-021 serdes_rx_valid=0 with serdes_in_valid=0 SHALL NOT emit unless REQ-016 holds on that edge.
REQ-022 slip_count SHALL increment by 1, modulo 128, for every applied slip (127 -> 0).
REQ-023 The gearbox SHALL apply no alignment search of its own; alignment is driven solely by serdes_rx_bitslip.

Reset
REQ-024 While rx_rst_n=0, the following SHALL be forced asynchronously to 0:
- B, C and the bitslip edge register
- serdes_rx_data, serdes_rx_hdr, serdes_rx_valid and slip_count
REQ-025 Deassertion SHALL be treated as synchronous to rx_clk. The first word accepted after reset SHALL start at B[0].
REQ-026 Reset asserted mid-block SHALL discard all partial bits. No block SHALL be emitted from pre-reset data.

Verification
REQ-027 Continuous stream of 66-bit blocks, hdr=2'b01, data=incrementing 64-bit count from 0, 33 words -> exactly 16 valid pulses; first block hdr=01, data=0; 16th block data=15.
REQ-028 Stream offset by 5 bits (5 leading filler bits), single 1-cycle bitslip pulse issued 5 times spaced 10 cycles apart -> after the 5th slip, every emitted hdr=01 with in-order data; slip_count=5.
REQ-029 serdes_rx_bitslip held high for 20 cycles -> exactly one slip applied (slip_count increments by 1).
REQ-030 serdes_in_valid toggling 1,0,1,0 -> blocks are still correct, with one valid pulse per 66 accepted bits; no pulse while C<66.
REQ-031 rx_rst_n pulsed low for 1 cycle after 40 bits are buffered -> all outputs 0 immediately; the next valid block is formed only from post-reset words.
REQ-032 BIT_REVERSE=1 with input word 32'h00000001 first -> that bit appears as B[31] (hdr bit positions are checked accordingly).
